// File: rtl/motor_pattern_if.sv
// Bundle of the enable/pattern inputs and drive/status outputs of the motor pattern serializer.
// frame_count exists only when MOTOR_FRAME_COUNT_EN is defined.
interface motor_pattern_if;
    logic       enable;
    logic [7:0] motor0;
    logic [7:0] motor1;
    logic [7:0] motor2;
    logic [7:0] motor3;
    logic [3:0] pwm;
    logic [2:0] bit_idx;
    logic       frame_start;
    logic [3:0] active;
`ifdef MOTOR_FRAME_COUNT_EN
    logic [7:0] frame_count;

    modport master (
        output enable, motor0, motor1, motor2, motor3,
        input  pwm, bit_idx, frame_start, active, frame_count
    );
    modport slave (
        input  enable, motor0, motor1, motor2, motor3,
        output pwm, bit_idx, frame_start, active, frame_count
    );
`else
    modport master (
        output enable, motor0, motor1, motor2, motor3,
        input  pwm, bit_idx, frame_start, active
    );
    modport slave (
        input  enable, motor0, motor1, motor2, motor3,
        output pwm, bit_idx, frame_start, active
    );
`endif
endinterface

// File: rtl/motor_pattern_serializer.sv
// Serializes four 8-bit motor patterns LSB first, DIV cycles per bit, reloading only at frame boundaries.
// Optional frame counter output enabled by defining MOTOR_FRAME_COUNT_EN.
module motor_pattern_serializer #(
    parameter int DIV = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    motor_pattern_if.slave  bus
);
    typedef enum logic {IDLE, RUN} state_t;

    localparam logic [15:0] DIV_LAST = 16'(DIV - 1);

    state_t      state_reg, state_next;
    logic [15:0] div_cnt_reg, div_cnt_next;
    logic [2:0]  bit_idx_reg, bit_idx_next;
    logic        frame_start_reg, frame_start_next;
    logic [7:0]  shadow_reg  [4];
    logic [7:0]  shadow_next [4];
    logic [7:0]  motor_in    [4];
    logic        tick;
`ifdef MOTOR_FRAME_COUNT_EN
    logic [7:0]  frame_count_reg, frame_count_next;
`endif

    assign motor_in[0] = bus.motor0;
    assign motor_in[1] = bus.motor1;
    assign motor_in[2] = bus.motor2;
    assign motor_in[3] = bus.motor3;

    assign tick = (div_cnt_reg == DIV_LAST);

    always_comb begin
        state_next       = state_reg;
        div_cnt_next     = div_cnt_reg;
        bit_idx_next     = bit_idx_reg;
        frame_start_next = 1'b0;
        for (int i = 0; i < 4; i++) shadow_next[i] = shadow_reg[i];
`ifdef MOTOR_FRAME_COUNT_EN
        frame_count_next = frame_count_reg;
`endif
        if (!bus.enable) begin
            // Abort anywhere in the frame: everything returns to its reset value.
            state_next   = IDLE;
            div_cnt_next = '0;
            bit_idx_next = '0;
            for (int i = 0; i < 4; i++) shadow_next[i] = '0;
`ifdef MOTOR_FRAME_COUNT_EN
            frame_count_next = '0;
`endif
        end else if (state_reg == IDLE) begin
            state_next       = RUN;
            div_cnt_next     = '0;
            bit_idx_next     = '0;
            frame_start_next = 1'b1;
            for (int i = 0; i < 4; i++) shadow_next[i] = motor_in[i];
        end else if (tick) begin
            div_cnt_next = '0;
            bit_idx_next = bit_idx_reg + 3'd1;
            if (bit_idx_reg == 3'd7) begin
                // Frame boundary: the only point where new patterns are accepted.
                frame_start_next = 1'b1;
                for (int i = 0; i < 4; i++) shadow_next[i] = motor_in[i];
`ifdef MOTOR_FRAME_COUNT_EN
                frame_count_next = frame_count_reg + 8'd1;
`endif
            end
        end else begin
            div_cnt_next = div_cnt_reg + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg       <= IDLE;
            div_cnt_reg     <= '0;
            bit_idx_reg     <= '0;
            frame_start_reg <= 1'b0;
            for (int i = 0; i < 4; i++) shadow_reg[i] <= '0;
`ifdef MOTOR_FRAME_COUNT_EN
            frame_count_reg <= '0;
`endif
        end else begin
            state_reg       <= state_next;
            div_cnt_reg     <= div_cnt_next;
            bit_idx_reg     <= bit_idx_next;
            frame_start_reg <= frame_start_next;
            for (int i = 0; i < 4; i++) shadow_reg[i] <= shadow_next[i];
`ifdef MOTOR_FRAME_COUNT_EN
            frame_count_reg <= frame_count_next;
`endif
        end
    end

    // Outputs come from registers only; no path from the inputs.
    for (genvar gi = 0; gi < 4; gi++) begin : g_chan
        assign bus.pwm[gi]    = (state_reg == RUN) & shadow_reg[gi][bit_idx_reg];
        assign bus.active[gi] = |shadow_reg[gi];
    end

    assign bus.bit_idx     = bit_idx_reg;
    assign bus.frame_start = frame_start_reg;
`ifdef MOTOR_FRAME_COUNT_EN
    assign bus.frame_count = frame_count_reg;
`endif

endmodule
